// File: rtl/trapez_peak_sampler.sv
// trapez_peak_sampler: measures the flat-top height of trapezoidal shaper pulses and reports one result per pulse.
// Ports: clk, reset (async active-low), shaper_data/shaper_valid (signed sample stream), arm (enable),
//   threshold (signed trigger level), height/height_valid/pileup (result), busy, event_count/pileup_count.
// Optional: define TRAPEZ_PEAK_FLATNESS_CHECK_EN to flag pile-up when the averaged flat top spread exceeds FLAT_TOL.
module trapez_peak_sampler #(
  parameter int DATA_W        = 16,
  parameter int RISE_LEN      = 32,
  parameter int FLAT_LEN      = 16,
  parameter int SAMPLE_OFFSET = 4,
  parameter int AVG_LOG2      = 3,
  parameter int CNT_W         = 16
`ifdef TRAPEZ_PEAK_FLATNESS_CHECK_EN
  , parameter int FLAT_TOL    = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] shaper_data,
  input  logic                     shaper_valid,
  input  logic                     arm,
  input  logic signed [DATA_W-1:0] threshold,
  output logic signed [DATA_W-1:0] height,
  output logic                     height_valid,
  output logic                     pileup,
  output logic                     busy,
  output logic [CNT_W-1:0]         event_count,
  output logic [CNT_W-1:0]         pileup_count
);
  localparam int AW = DATA_W + AVG_LOG2;
  localparam int TW = $clog2(2 * RISE_LEN + SAMPLE_OFFSET + 1);
  localparam logic [TW-1:0] RISE_END = TW'(RISE_LEN + SAMPLE_OFFSET - 1);
  localparam logic [TW-1:0] FALL_END = TW'(2 * RISE_LEN - 1);
  localparam logic [AVG_LOG2-1:0] ACC_END = '1;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RISE  = 3'd1;
  localparam logic [2:0] ACCUM = 3'd2;
  localparam logic [2:0] FALL  = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;
  if (SAMPLE_OFFSET + 2 ** AVG_LOG2 > FLAT_LEN) begin : g_bad_cfg
    $fatal(1, "trapez_peak_sampler: averaging window extends past the flat top");
  end
  logic [2:0]          state;
  logic [TW-1:0]       tcnt;
  logic [AVG_LOG2-1:0] acnt;
  logic [AW-1:0]       acc;
  logic                prev_above, pend;
  logic                above, emit, emit_pu, flat_bad;
  assign busy = state != IDLE;
`ifdef TRAPEZ_PEAK_FLATNESS_CHECK_EN
  logic signed [DATA_W-1:0] mn, mx;
  logic [DATA_W:0]          spread;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mn <= '0;
      mx <= '0;
    end else if (arm && shaper_valid && state == ACCUM) begin
      mn <= (acnt == '0 || shaper_data < mn) ? shaper_data : mn;
      mx <= (acnt == '0 || shaper_data > mx) ? shaper_data : mx;
    end
  // mx >= mn always, so the widened difference is non-negative
  assign spread   = {mx[DATA_W-1], mx} - {mn[DATA_W-1], mn};
  assign flat_bad = spread > (DATA_W + 1)'(FLAT_TOL);
`else
  assign flat_bad = 1'b0;
`endif
  always_comb begin
    above   = shaper_data > threshold;
    emit    = shaper_valid && arm && state == FALL && (!above || tcnt == FALL_END);
    // still above at emission time means the FALL timeout fired
    emit_pu = pend || above || flat_bad;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      prev_above   <= 1'b1;
      tcnt         <= '0;
      acnt         <= '0;
      acc          <= '0;
      pend         <= 1'b0;
      height       <= '0;
      height_valid <= 1'b0;
      pileup       <= 1'b0;
      event_count  <= '0;
      pileup_count <= '0;
    end else begin
      height_valid <= emit;
      pileup       <= emit && emit_pu;
      if (emit) begin
        height <= acc[AW-1:AVG_LOG2];
        if (emit_pu) pileup_count <= &pileup_count ? pileup_count : pileup_count + 1'b1;
        else event_count <= &event_count ? event_count : event_count + 1'b1;
      end
      if (shaper_valid) prev_above <= above;
      if (!arm) state <= IDLE;
      else if (shaper_valid)
        case (state)
          IDLE: if (above && !prev_above) begin
            state <= RISE;
            tcnt  <= '0;
            pend  <= 1'b0;
          end
          RISE: begin
            pend <= pend | !above;
            tcnt <= tcnt + 1'b1;
            if (tcnt == RISE_END) begin
              state <= ACCUM;
              acc   <= '0;
              acnt  <= '0;
            end
          end
          ACCUM: begin
            pend <= pend | !above;
            acc  <= acc + {{AVG_LOG2{shaper_data[DATA_W-1]}}, shaper_data};
            acnt <= acnt + 1'b1;
            if (acnt == ACC_END) begin
              state <= FALL;
              tcnt  <= '0;
            end
          end
          FALL: begin
            tcnt <= tcnt + 1'b1;
            if (emit) state <= above ? HOLD : IDLE;
          end
          HOLD: if (!above) state <= IDLE;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_trapez_peak_sampler.sv
// tb_trapez_peak_sampler: directed trapezoid stimulus with hand-computed heights, flags, counters and latencies.
module tb_trapez_peak_sampler;
  logic clk = 1'b0, reset = 1'b0, shaper_valid = 1'b0, arm = 1'b1;
  logic signed [15:0] shaper_data = '0, threshold = 16'sd100;
  logic signed [15:0] height;
  logic height_valid, pileup, busy;
  logic [15:0] event_count, pileup_count;
  int n_cmp = 0, n_bad = 0, nres = 0, last_h = 0, last_p = 0, last_cyc = 0, cyc = 0, t0 = 0;
  bit busy_seen = 1'b0;
  trapez_peak_sampler dut (
    .clk(clk), .reset(reset), .shaper_data(shaper_data), .shaper_valid(shaper_valid), .arm(arm),
    .threshold(threshold), .height(height), .height_valid(height_valid), .pileup(pileup), .busy(busy),
    .event_count(event_count), .pileup_count(pileup_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (height_valid) begin
      nres++;
      last_h = height;
      last_p = pileup;
      last_cyc = cyc;
    end
    if (busy) busy_seen = 1'b1;
  end
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int tz(input int k, input int p);
    if (k <= 0) return 0;
    if (k <= 32) return k * p / 32;
    if (k <= 48) return p;
    if (k <= 80) return p - (k - 48) * p / 32;
    return 0;
  endfunction
  // mode 0 ideal, 1 flat 998/1002, 2 flat 900/1100, 3 two overlapping pulses, 4 negative pulse
  function automatic int val(input int k, input int mode);
    if ((mode == 1 || mode == 2) && k > 32 && k <= 48)
      return (k % 2 != 0) ? (mode == 1 ? 998 : 900) : (mode == 1 ? 1002 : 1100);
    if (mode == 3) return tz(k, 1000) + tz(k - 56, 1000);
    return tz(k, mode == 4 ? -1000 : 1000);
  endfunction
  task automatic drive(input int v, input bit vld);
    @(negedge clk);
    shaper_data = 16'(v);
    shaper_valid = vld;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 1'b1);
  endtask
  task automatic run(input int mode, input int nk, input bit tog);
    for (int k = 1; k <= nk; k++) begin
      drive(val(k, mode), 1'b1);
      if (k == 1) t0 = cyc;
      if (tog) drive(30000, 1'b0);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_height", height, 0);
    check("rst_hvalid", height_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_evcnt", event_count, 0);
    #2 reset = 1'b1;
    idle(4);
    run(0, 85, 1'b0);
    idle(6);
    check("ideal_nres", nres, 1);
    check("ideal_height", last_h, 1000);
    check("ideal_pileup", last_p, 0);
    check("ideal_evcnt", event_count, 1);
    check("ideal_pucnt", pileup_count, 0);
    check("ideal_busy", busy, 0);
    check("ideal_latency", last_cyc - t0, 77);
    run(1, 85, 1'b0);
    idle(6);
    check("ripple_nres", nres, 2);
    check("ripple_height", last_h, 1000);
    check("ripple_evcnt", event_count, 2);
    busy_seen = 1'b0;
    run(4, 85, 1'b0);
    idle(6);
    check("neg_busy", busy_seen, 0);
    check("neg_nres", nres, 2);
    run(3, 140, 1'b0);
    idle(6);
    check("pileup_nres", nres, 3);
    check("pileup_height", last_h, 1000);
    check("pileup_flag", last_p, 1);
    check("pileup_pucnt", pileup_count, 1);
    check("pileup_evcnt", event_count, 2);
    run(0, 85, 1'b1);
    idle(6);
    check("toggle_nres", nres, 4);
    check("toggle_height", last_h, 1000);
    check("toggle_pileup", last_p, 0);
    check("toggle_evcnt", event_count, 3);
    check("toggle_latency", last_cyc - t0, 153);
    for (int k = 1; k <= 85; k++) begin
      arm = (k >= 43 && k < 45) ? 1'b0 : 1'b1;
      drive(val(k, 0), 1'b1);
      if (k == 42) check("disarm_busy_before", busy, 1);
      if (k == 44) check("disarm_busy_after", busy, 0);
    end
    idle(6);
    check("disarm_nres", nres, 4);
    check("disarm_evcnt", event_count, 3);
    run(0, 85, 1'b0);
    idle(6);
    check("rearm_nres", nres, 5);
    check("rearm_evcnt", event_count, 4);
    for (int k = 1; k <= 60; k++) drive(val(k, 0), 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_height", height, 0);
    check("arst_busy", busy, 0);
    check("arst_evcnt", event_count, 0);
    check("arst_pucnt", pileup_count, 0);
    check("arst_hvalid", height_valid, 0);
    #5 reset = 1'b1;
    idle(4);
    run(0, 85, 1'b0);
    idle(6);
    check("post_nres", nres, 6);
    check("post_height", last_h, 1000);
    check("post_pileup", last_p, 0);
    check("post_evcnt", event_count, 1);
    run(2, 85, 1'b0);
    idle(6);
    check("wide_nres", nres, 7);
    check("wide_height", last_h, 1000);
`ifdef TRAPEZ_PEAK_FLATNESS_CHECK_EN
    check("wide_pileup", last_p, 1);
    check("wide_pucnt", pileup_count, 1);
    check("wide_evcnt", event_count, 1);
`else
    check("wide_pileup", last_p, 0);
    check("wide_pucnt", pileup_count, 0);
    check("wide_evcnt", event_count, 2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
